// File: rtl/tx_iq_shaper.sv
// Paced I/Q transmit back end: input FIFO, sample-rate pacing, gain, linear
// keying envelope, and truncation with saturation to DAC width.
module tx_iq_shaper #(
  parameter int unsigned IN_BITS    = 24,
  parameter int unsigned DAC_BITS   = 14,
  parameter int unsigned RATE       = 1280,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAMP_STEPS = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tx_enable,
  input  logic [7:0]                 gain,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_BITS-1:0]  in_data_I,
  input  logic signed [IN_BITS-1:0]  in_data_Q,
  input  logic                       out_sel,
  output logic                       out_strobe,
  output logic signed [DAC_BITS-1:0] out_data_I,
  output logic signed [DAC_BITS-1:0] out_data_Q,
  output logic signed [DAC_BITS-1:0] dac_data,
  output logic                       clip,
  output logic                       underflow
);
  localparam int unsigned CNT_W  = $clog2(RATE);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned ENV_W  = $clog2(RAMP_STEPS) + 1;
  localparam int unsigned P1_W   = IN_BITS + 9;
  localparam int unsigned P_W    = P1_W + ENV_W + 1;
  localparam int unsigned SHIFT  = 7 + $clog2(RAMP_STEPS) + IN_BITS - DAC_BITS;

  localparam logic signed [P_W-1:0] Y_MAX    = P_W'((1 << (DAC_BITS - 1)) - 1);
  localparam logic signed [P_W-1:0] Y_MIN    = ~Y_MAX;
  localparam logic [ENV_W-1:0]      ENV_FULL = ENV_W'(RAMP_STEPS);

  typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;

  state_t                    state, state_nx;
  logic [ENV_W-1:0]          env, env_nx;
  logic [CNT_W-1:0]          rate_cnt;
  logic signed [IN_BITS-1:0] fifo_i [FIFO_DEPTH];
  logic signed [IN_BITS-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]         fifo_cnt;
  logic signed [IN_BITS-1:0] sample_i, sample_q;
  logic                      tick_q1, valid_q2;
  logic signed [P1_W-1:0]    prod_i, prod_q;

  logic                      tick_c, wr_c, pop_c, empty_c, clip_c;
  logic signed [8:0]         gain_s_c;
  logic signed [ENV_W:0]     env_s_c;
  logic signed [P_W-1:0]     y_i_c, y_q_c;
  logic signed [DAC_BITS-1:0] sat_i_c, sat_q_c;

  assign tick_c   = (rate_cnt == CNT_W'(RATE - 1));
  assign empty_c  = (fifo_cnt == '0);
  assign in_ready = !reset && (fifo_cnt < FCNT_W'(FIFO_DEPTH));
  assign wr_c     = in_valid && in_ready;
  assign pop_c    = tick_c && !empty_c;

  // Sample-rate pacing
  always_ff @(posedge clock) begin
    if (reset || tick_c) rate_cnt <= '0;
    else                 rate_cnt <= rate_cnt + CNT_W'(1);
  end

  // FIFO storage needs no reset; flushing is done through the pointers
  always_ff @(posedge clock) begin
    if (wr_c) begin
      fifo_i[wr_ptr] <= in_data_I;
      fifo_q[wr_ptr] <= in_data_Q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_c)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sample register holds the previous sample when the FIFO runs dry
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_i  <= '0;
      sample_q  <= '0;
      underflow <= 1'b0;
    end else if (tick_c) begin
      if (!empty_c) begin
        sample_i <= fifo_i[rd_ptr];
        sample_q <= fifo_q[rd_ptr];
      end else if (state != IDLE) begin
        underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      env   <= '0;
    end else begin
      state <= state_nx;
      env   <= env_nx;
    end
  end

  // Envelope: direction changes keep the current level so there is no step
  always_comb begin
    state_nx = state;
    env_nx   = env;
    if (tick_c) begin
      case (state)
        IDLE: if (tx_enable) state_nx = RAMP_UP;
        RAMP_UP: begin
          if (!tx_enable) begin
            state_nx = RAMP_DOWN;
          end else if (env >= ENV_FULL - ENV_W'(1)) begin
            env_nx   = ENV_FULL;
            state_nx = ON;
          end else begin
            env_nx = env + ENV_W'(1);
          end
        end
        ON: if (!tx_enable) state_nx = RAMP_DOWN;
        RAMP_DOWN: begin
          if (tx_enable) begin
            state_nx = RAMP_UP;
          end else if (env <= ENV_W'(1)) begin
            env_nx   = '0;
            state_nx = IDLE;
          end else begin
            env_nx = env - ENV_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          env_nx   = '0;
        end
      endcase
    end
  end

  assign gain_s_c = $signed({1'b0, gain});

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q1  <= 1'b0;
      valid_q2 <= 1'b0;
      prod_i   <= '0;
      prod_q   <= '0;
    end else begin
      tick_q1  <= tick_c;
      valid_q2 <= tick_q1;
      if (tick_q1) begin
        prod_i <= P1_W'(sample_i) * P1_W'(gain_s_c);
        prod_q <= P1_W'(sample_q) * P1_W'(gain_s_c);
      end
    end
  end

  function automatic logic signed [DAC_BITS-1:0] sat(input logic signed [P_W-1:0] y);
    if (y > Y_MAX)      return DAC_BITS'(Y_MAX);
    else if (y < Y_MIN) return DAC_BITS'(Y_MIN);
    else                return DAC_BITS'(y);
  endfunction

  // Full-precision envelope product, floor shift, then clamp
  always_comb begin
    env_s_c = $signed({1'b0, env});
    y_i_c   = (P_W'(prod_i) * P_W'(env_s_c)) >>> SHIFT;
    y_q_c   = (P_W'(prod_q) * P_W'(env_s_c)) >>> SHIFT;
    sat_i_c = sat(y_i_c);
    sat_q_c = sat(y_q_c);
    clip_c  = (y_i_c > Y_MAX) || (y_i_c < Y_MIN) || (y_q_c > Y_MAX) || (y_q_c < Y_MIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_strobe <= 1'b0;
      clip       <= 1'b0;
      out_data_I <= '0;
      out_data_Q <= '0;
      dac_data   <= '0;
    end else begin
      out_strobe <= valid_q2;
      clip       <= valid_q2 && clip_c;
      if (valid_q2) begin
        out_data_I <= sat_i_c;
        out_data_Q <= sat_q_c;
        dac_data   <= out_sel ? sat_q_c : sat_i_c;
      end
    end
  end

endmodule

// File: doc/tx_iq_shaper.md
# tx_iq_shaper

Parametrised transmit back end, successor to the fixed-rate transmitter path.
- Accepts baseband I/Q through a valid/ready FIFO and paces it out at a programmable sample rate.
- Applies a programmable gain and a linear TX-keying envelope (ramp up/down), then truncates and saturates to DAC width.
- Output drives the CORDIC/DAC stage directly. Replaces ad-hoc latching, fixed gain trimming and DAC wrap-around with explicit, saturating behaviour.

## Interface
- IN_BITS, 24: signed input sample width.
- DAC_BITS, 14: signed output width; must be < IN_BITS.
- RATE, 1280: clocks per output sample; ≥ 4.
- FIFO_DEPTH, 8: input FIFO entries; power of 2.
- RAMP_STEPS, 256: envelope full-scale; power of 2, ≥ 2.

Ports (clock and reset first):
- clock  in  1  sample clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- tx_enable  in  1  key request.
- gain  in  8  unsigned; 128 = unity, 255 ≈ 1.99.
- in_valid  in  1  input sample present.
- in_ready  out  1  FIFO can accept.
- in_data_I, in_data_Q  in  IN_BITS  signed input samples.
- out_sel  in  1  selects dac_data source: 0 = I, 1 = Q.
- out_strobe  out  1  one-cycle pulse when outputs update.
- out_data_I, out_data_Q  out  DAC_BITS  signed shaped samples.
- dac_data  out  DAC_BITS  selected channel.
- clip  out  1  one-cycle pulse, coincident with out_strobe, if either channel saturated.
- underflow  out  1  sticky; cleared only by reset.

## Operation
- **FIFO**
  - Write occurs when in_valid && in_ready.
  - in_ready = !reset && (count < FIFO_DEPTH), derived from the registered count.
  - A write and a pop in the same cycle leave count unchanged.
  - While full, in_ready is 0, so no write is accepted even if a pop happens that cycle.
- **Rate counter**
  - Counts 0..RATE-1 and wraps.
  - tick is asserted when the count equals RATE-1.
- **On tick**
  - If the FIFO is non-empty, pop the head into the sample register.
  - If the FIFO is empty, hold the previous sample. In any state other than IDLE, also set underflow.
  - In IDLE, samples are still popped; the output is zero because env = 0.
- **Envelope FSM** (advances on tick only; env range 0..RAMP_STEPS)
  - IDLE, env = 0: if tx_enable, go to RAMP_UP.
  - RAMP_UP: env += 1. When env reaches RAMP_STEPS, go to ON. If !tx_enable, go to RAMP_DOWN with no env jump.
  - ON, env = RAMP_STEPS: if !tx_enable, go to RAMP_DOWN.
  - RAMP_DOWN: env -= 1. When env reaches 0, go to IDLE. If tx_enable, go to RAMP_UP with no env jump.
- **Arithmetic** (per channel, full precision, no intermediate truncation)
  - p = sample × gain × env.
  - y = p >>> (7 + log2(RAMP_STEPS) + IN_BITS − DAC_BITS), arithmetic shift (floor).
  - Saturate y to [−2^(DAC_BITS−1), 2^(DAC_BITS−1)−1].
  - dac_data is registered as out_sel ? Q : I. out_sel is sampled in the output stage.

## Timing
- Tick occurs at cycle T.
- T+1: sample register and env are updated.
- T+2: sample × gain is registered. gain is sampled here.
- T+3: out_data_I, out_data_Q, dac_data and clip are updated, and out_strobe = 1 for that one cycle.
- The output at T+3 uses the env value updated at T+1.
- Steady state: one out_strobe every RATE clocks. Outputs hold between strobes.
- Reset (any cycle, including mid-ramp or with a full FIFO), on the next edge:
  - FIFO is flushed, rate counter = 0, FSM = IDLE, env = 0.
  - Pipeline is cleared.
  - All outputs = 0: out_strobe, clip, underflow, out_data_*, dac_data.
- in_ready is 0 while reset is high and 1 on the first cycle after release.
- First tick after reset occurs RATE−1 cycles after release.

## Test plan
Bench parameters: RATE=8, RAMP_STEPS=4, DAC_BITS=14, IN_BITS=24, gain=128 unless stated.

1. **Reset:** assert reset mid-ramp with FIFO holding 3 entries → next cycle all outputs 0, FSM IDLE; after release in_ready=1 and the first out_strobe at cycle RATE−1+3 shows 0.
2. **Ramp up:** tx_enable=1, stream constant I=0x7FFF00, Q=0 → successive out_data_I = 2047, 4095, 6143, 8191, then 8191 steady; Q=0; clip never set.
3. **Saturation:** ON state, gain=255, I=0x7FFF00, Q=0x800000 → out_data_I=8191, out_data_Q=−8192, clip pulses with each strobe; dac_data follows out_sel.
4. **Backpressure:** tx_enable=0, in_valid held 1 for 12 cycles before the first tick → exactly 8 writes accepted; in_ready=0 until the next tick pops one entry.
5. **Underflow:** in ON, stop in_valid and drain the FIFO → out_data_I holds the last value and underflow=1, remaining 1 through further traffic until reset.
6. **Abort ramp:** drop tx_enable when env=2 during RAMP_UP with I=0x7FFF00 → outputs 4095, 2047, 0, then IDLE with output 0; re-asserting tx_enable during RAMP_DOWN at env=1 resumes at env=2 with no jump.
